// File: rtl/dtw_job_ctrl_pkg.sv
// dtw_job_ctrl_pkg: shared constants for the DTW job sequencer.
// FSM state encoding, response status codes, command opcodes.
package dtw_job_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRST,
    ST_LOAD,
    ST_QRY,
    ST_QWAIT,
    ST_RESP,
    ST_ABORT
  } state_e;

  localparam logic [1:0] RSP_OK      = 2'd0;
  localparam logic [1:0] RSP_NOREF   = 2'd1;
  localparam logic [1:0] RSP_BADLEN  = 2'd2;
  localparam logic [1:0] RSP_TIMEOUT = 2'd3;

  localparam logic OP_QUERY    = 1'b0;
  localparam logic OP_LOAD_REF = 1'b1;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dtw_job_feed.sv
// dtw_job_feed: meters a fixed word budget from the source FIFO into the core.
// Ports: load_i/budget_i arm a new budget; feeding_i opens the gate;
// up_src_empty_i/core_src_rden_i in; core_src_empty_o/up_src_rden_o out;
// exhausted_o when all budgeted words popped; progress_o per word popped.
module dtw_job_feed
  import dtw_job_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] budget_i,
  input  logic        feeding_i,
  input  logic        up_src_empty_i,
  input  logic        core_src_rden_i,
  output logic        core_src_empty_o,
  output logic        up_src_rden_o,
  output logic        exhausted_o,
  output logic        progress_o
);

  logic [31:0] budget_q, budget_d;
  logic [31:0] words_q, words_d;

  assign exhausted_o = (words_q == budget_q);

  // The core only ever sees data while a budget is open and words remain,
  // so the source can never be over-popped whatever the core does.
  assign core_src_empty_o = up_src_empty_i | ~feeding_i | exhausted_o;
  assign up_src_rden_o = core_src_rden_i & ~core_src_empty_o;
  assign progress_o = up_src_rden_o;

  always_comb begin
    budget_d = budget_q;
    words_d = words_q;
    if (load_i) begin
      budget_d = budget_i;
      words_d = '0;
    end else if (up_src_rden_o) begin
      words_d = words_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      budget_q <= '0;
      words_q <= '0;
    end else begin
      budget_q <= budget_d;
      words_q <= words_d;
    end
  end

endmodule

// File: rtl/dtw_job_ctrl.sv
// dtw_job_ctrl: command sequencer for one dtw_core (LOAD_REF / QUERY).
// Ports: cmd_* command in, rsp_* status out, core_* to/from dtw_core,
// up_src_* to the source FIFO. DTW_JOB_CTRL_PERF_EN adds perf_* counters.
module dtw_job_ctrl
  import dtw_job_ctrl_pkg::*;
#(
  parameter int SQG_SIZE     = 250,
  parameter int REF_MAX      = 32768,
  parameter int CORE_RST_CYC = 4,
  parameter int TIMEOUT_CYC  = 1 << 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [31:0] cmd_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_status,
  output logic        ref_valid,
  output logic        core_rst,
  output logic        core_rs,
  output logic        core_op_mode,
  output logic [31:0] core_ref_len,
  input  logic        core_busy,
  input  logic        core_load_done,
  input  logic        core_src_rden,
  output logic        core_src_empty,
  input  logic        up_src_empty,
`ifdef DTW_JOB_CTRL_PERF_EN
  output logic [31:0] perf_busy_cyc,
  output logic [31:0] perf_stall_cyc,
`endif
  output logic        up_src_rden
);

  localparam logic [31:0] SQG32  = 32'(SQG_SIZE);
  localparam logic [31:0] RMAX32 = 32'(REF_MAX);
  localparam logic [31:0] RSTL   = 32'(CORE_RST_CYC - 1);
  localparam logic [31:0] TMOL   = 32'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [1:0]  status_q, status_d;
  logic        ref_valid_q, ref_valid_d;
  logic [31:0] ref_len_q, ref_len_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] tmo_q, tmo_d;
  logic        done_seen_q, done_seen_d;
  logic        busy_seen_q, busy_seen_d;
  logic        busy_q, load_done_q;

  logic        feed_load;
  logic [31:0] feed_budget;
  logic        feeding_c, feeding;
  logic        exhausted, feed_prog;
  logic        cmd_ready_c, rsp_valid_c;
  logic        core_rst_c, core_rs_c, op_mode_c;
  logic        is_load, len_bad;
  logic        load_rise, progress, watched, tmo_hit;

  assign is_load = (cmd_op == OP_LOAD_REF);
  assign len_bad = (cmd_len == 32'd0) || (cmd_len > RMAX32);
  assign load_rise = core_load_done & ~load_done_q;

  // Any edge on busy/load_done counts as the core being alive.
  assign progress = feed_prog
                  | (core_busy ^ busy_q)
                  | (core_load_done ^ load_done_q);

  assign watched = (state_q == ST_CRST) || (state_q == ST_LOAD)
                || (state_q == ST_QRY)  || (state_q == ST_QWAIT);
  assign tmo_hit = watched & ~progress & (tmo_q == TMOL);

  assign feeding = feeding_c & ~rst;

  dtw_job_feed u_feed (
    .clk              (clk),
    .rst              (rst),
    .load_i           (feed_load),
    .budget_i         (feed_budget),
    .feeding_i        (feeding),
    .up_src_empty_i   (up_src_empty),
    .core_src_rden_i  (core_src_rden),
    .core_src_empty_o (core_src_empty),
    .up_src_rden_o    (up_src_rden),
    .exhausted_o      (exhausted),
    .progress_o       (feed_prog)
  );

  always_comb begin
    state_d = state_q;
    status_d = status_q;
    ref_valid_d = ref_valid_q;
    ref_len_d = ref_len_q;
    done_seen_d = done_seen_q;
    busy_seen_d = busy_seen_q;
    feed_load = 1'b0;
    feed_budget = SQG32;
    feeding_c = 1'b0;
    cmd_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    core_rst_c = 1'b0;
    core_rs_c = 1'b0;
    op_mode_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_c = 1'b1;
        if (cmd_valid) begin
          unique case (1'b1)
            is_load & len_bad: begin
              status_d = RSP_BADLEN;
              state_d = ST_RESP;
            end
            is_load & ~len_bad: begin
              ref_len_d = cmd_len;
              ref_valid_d = 1'b0;
              feed_load = 1'b1;
              feed_budget = cmd_len;
              done_seen_d = 1'b0;
              state_d = ST_CRST;
            end
            ~is_load & ~ref_valid_q: begin
              status_d = RSP_NOREF;
              state_d = ST_RESP;
            end
            default: begin
              feed_load = 1'b1;
              feed_budget = SQG32;
              busy_seen_d = 1'b0;
              state_d = ST_QRY;
            end
          endcase
        end
      end
      ST_CRST: begin
        core_rst_c = 1'b1;
        op_mode_c = 1'b1;
        if (cnt_q == RSTL) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        core_rs_c = 1'b1;
        op_mode_c = 1'b1;
        feeding_c = 1'b1;
        if (load_rise) done_seen_d = 1'b1;
        if ((load_rise | done_seen_q) & exhausted) begin
          ref_valid_d = 1'b1;
          status_d = RSP_OK;
          state_d = ST_RESP;
        end
      end
      ST_QRY: begin
        core_rs_c = 1'b1;
        feeding_c = 1'b1;
        if (core_busy) busy_seen_d = 1'b1;
        if (exhausted) state_d = ST_QWAIT;
      end
      ST_QWAIT: begin
        core_rs_c = 1'b1;
        if (core_busy) busy_seen_d = 1'b1;
        if (busy_seen_q & ~core_busy) begin
          status_d = RSP_OK;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid_c = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      ST_ABORT: begin
        core_rst_c = 1'b1;
        ref_valid_d = 1'b0;
        if (cnt_q == RSTL) begin
          status_d = RSP_TIMEOUT;
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmo_hit) begin
      ref_valid_d = 1'b0;
      state_d = ST_ABORT;
    end
    cnt_d = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
    tmo_d = ((state_d != state_q) || progress) ? 32'd0 : tmo_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      status_q <= RSP_OK;
      ref_valid_q <= 1'b0;
      ref_len_q <= '0;
      cnt_q <= '0;
      tmo_q <= '0;
      done_seen_q <= 1'b0;
      busy_seen_q <= 1'b0;
      busy_q <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      status_q <= status_d;
      ref_valid_q <= ref_valid_d;
      ref_len_q <= ref_len_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      done_seen_q <= done_seen_d;
      busy_seen_q <= busy_seen_d;
      busy_q <= core_busy;
      load_done_q <= core_load_done;
    end
  end

  // rst forces reset values onto the outputs in the same cycle.
  assign cmd_ready    = cmd_ready_c & ~rst;
  assign rsp_valid    = rsp_valid_c & ~rst;
  assign rsp_status   = rst ? RSP_OK : status_q;
  assign ref_valid    = ref_valid_q & ~rst;
  assign core_rst     = core_rst_c | rst;
  assign core_rs      = core_rs_c & ~rst;
  assign core_op_mode = op_mode_c & ~rst;
  assign core_ref_len = rst ? 32'd0 : ref_len_q;

`ifdef DTW_JOB_CTRL_PERF_EN
  logic [31:0] perf_busy_q, perf_stall_q;
  logic        in_job, stall;

  assign in_job = (state_q == ST_LOAD) || (state_q == ST_QRY)
               || (state_q == ST_QWAIT);
  assign stall = feeding & up_src_empty & ~exhausted;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (in_job) perf_busy_q <= sat_inc(perf_busy_q);
      if (stall) perf_stall_q <= sat_inc(perf_stall_q);
    end
  end

  assign perf_busy_cyc = perf_busy_q;
  assign perf_stall_cyc = perf_stall_q;
`endif

endmodule

// File: tb/tb_dtw_job_ctrl.sv
// tb_dtw_job_ctrl: randomized bench for dtw_job_ctrl with a behavioural
// dtw_core/FIFO model and a command-level reference model.
module tb_dtw_job_ctrl;

  localparam int SQG  = 250;
  localparam int RMAX = 32768;
  localparam int TMO  = 64;
  localparam int RSTC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [31:0] cmd_len = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [1:0]  rsp_status;
  logic        ref_valid;
  logic        core_rst, core_rs, core_op_mode;
  logic [31:0] core_ref_len;
  logic        core_busy = 1'b0;
  logic        core_load_done = 1'b0;
  logic        core_src_rden;
  logic        core_src_empty;
  logic        up_src_empty = 1'b0;
  logic        up_src_rden;
`ifdef DTW_JOB_CTRL_PERF_EN
  logic [31:0] perf_busy_cyc, perf_stall_cyc;
`endif

  always #5 clk = ~clk;

  dtw_job_ctrl #(
    .SQG_SIZE     (SQG),
    .REF_MAX      (RMAX),
    .CORE_RST_CYC (RSTC),
    .TIMEOUT_CYC  (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_len        (cmd_len),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_status     (rsp_status),
    .ref_valid      (ref_valid),
    .core_rst       (core_rst),
    .core_rs        (core_rs),
    .core_op_mode   (core_op_mode),
    .core_ref_len   (core_ref_len),
    .core_busy      (core_busy),
    .core_load_done (core_load_done),
    .core_src_rden  (core_src_rden),
    .core_src_empty (core_src_empty),
    .up_src_empty   (up_src_empty),
`ifdef DTW_JOB_CTRL_PERF_EN
    .perf_busy_cyc  (perf_busy_cyc),
    .perf_stall_cyc (perf_stall_cyc),
`endif
    .up_src_rden    (up_src_rden)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Environment knobs, written only by the main initial block.
  int empty_mode = 0;
  bit never_done = 1'b0;

  int  cyc = 0;
  bit  rden_en = 1'b1;
  int  pop_total = 0;
  int  overpop = 0;
  int  rs_hi = 0;
  int  crst_hi = 0;
  int  mpops = 0;
  int  tail = 0;

  // Source FIFO emptiness pattern and core read eagerness.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    rden_en <= ($urandom_range(0, 4) != 0);
    case (empty_mode)
      1:       up_src_empty <= ((cyc % 8) == 7);
      2:       up_src_empty <= ($urandom_range(0, 3) == 0);
      default: up_src_empty <= 1'b0;
    endcase
    rs_hi <= rs_hi + int'(core_rs);
    crst_hi <= crst_hi + int'(core_rst);
  end

  // Core asks for data whenever running; the controller must gate it.
  assign core_src_rden = core_rs & rden_en;

  always @(posedge clk) begin
    if (up_src_rden) pop_total <= pop_total + 1;
    if (up_src_rden && up_src_empty) overpop <= overpop + 1;
  end

  // Behavioural dtw_core: load_done after ref_len words, busy over a query.
  always @(posedge clk) begin
    if (core_rst) begin
      mpops <= 0;
      tail <= 0;
      core_busy <= 1'b0;
      core_load_done <= 1'b0;
    end else if (!core_rs) begin
      mpops <= 0;
      tail <= 0;
      core_busy <= 1'b0;
    end else begin
      if (up_src_rden) mpops <= mpops + 1;
      if (core_op_mode) begin
        if (!never_done && mpops == int'(core_ref_len))
          core_load_done <= 1'b1;
      end else begin
        if (up_src_rden) core_busy <= 1'b1;
        if (up_src_rden && mpops == SQG - 1)
          tail <= $urandom_range(2, 10);
        else if (tail > 1)
          tail <= tail - 1;
        else if (tail == 1) begin
          tail <= 0;
          core_busy <= 1'b0;
        end
      end
    end
  end

  // Reference model state: does the core hold a reference?
  bit model_rv = 1'b0;

  function automatic logic [1:0] ref_status(
    input bit op, input logic [31:0] len, input bit rv
  );
    if (op) return (len == 0 || len > RMAX) ? 2'd2 : 2'd0;
    return rv ? 2'd0 : 2'd1;
  endfunction

  function automatic int ref_pops(
    input bit op, input logic [31:0] len, input logic [1:0] st
  );
    if (st != 2'd0) return 0;
    return op ? int'(len) : SQG;
  endfunction

  task automatic send_cmd(
    input bit op, input logic [31:0] len, output bit ok
  );
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_ready;
    if (ok) begin
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_len = len;
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(
    input int limit, output bit got, output logic [1:0] st,
    output int waited, output logic busy_at
  );
    waited = 0;
    while (!rsp_valid && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    got = rsp_valid;
    st = rsp_status;
    busy_at = core_busy;
    if (got) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp += 10;
    if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready got %b want 0", cmd_ready); end
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    if (rsp_status !== 2'd0) begin n_bad++; $display("FAIL rst_status got %0d want 0", rsp_status); end
    if (ref_valid !== 1'b0) begin n_bad++; $display("FAIL rst_ref_valid got %b want 0", ref_valid); end
    if (core_rst !== 1'b1) begin n_bad++; $display("FAIL rst_core_rst got %b want 1", core_rst); end
    if (core_rs !== 1'b0) begin n_bad++; $display("FAIL rst_core_rs got %b want 0", core_rs); end
    if (core_op_mode !== 1'b0) begin n_bad++; $display("FAIL rst_op_mode got %b want 0", core_op_mode); end
    if (core_ref_len !== 32'd0) begin n_bad++; $display("FAIL rst_ref_len got %0d want 0", core_ref_len); end
    if (core_src_empty !== 1'b1) begin n_bad++; $display("FAIL rst_src_empty got %b want 1", core_src_empty); end
    if (up_src_rden !== 1'b0) begin n_bad++; $display("FAIL rst_rden got %b want 0", up_src_rden); end
    rst = 1'b0;
    model_rv = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL idle_cmd_ready got %b want 1", cmd_ready); end
    if (core_rst !== 1'b0) begin n_bad++; $display("FAIL idle_core_rst got %b want 0", core_rst); end
  endtask

  task automatic test_noref();
    bit ok, got;
    logic [1:0] st;
    logic b;
    int w, p0, r0;
    p0 = pop_total;
    r0 = rs_hi;
    send_cmd(1'b0, 32'd0, ok);
    wait_rsp(10, got, st, w, b);
    n_cmp += 5;
    if (!(ok && got)) begin n_bad++; $display("FAIL noref_handshake got ok=%b rsp=%b want 1/1", ok, got); end
    if (st !== ref_status(1'b0, 0, model_rv)) begin n_bad++; $display("FAIL noref_status got %0d want 1", st); end
    if (w > 1) begin n_bad++; $display("FAIL noref_latency got %0d want <=1", w); end
    if (pop_total - p0 != 0) begin n_bad++; $display("FAIL noref_pops got %0d want 0", pop_total - p0); end
    if (rs_hi != r0) begin n_bad++; $display("FAIL noref_core_rs got %0d high cycles want 0", rs_hi - r0); end
  endtask

  task automatic test_badlen();
    bit ok, got;
    logic [1:0] st;
    logic b;
    int w;
    logic [31:0] lens [3];
    lens[0] = 32'd0;
    lens[1] = 32'(RMAX + 1);
    lens[2] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      send_cmd(1'b1, lens[i], ok);
      wait_rsp(10, got, st, w, b);
      n_cmp += 2;
      if (!(ok && got) || st !== ref_status(1'b1, lens[i], model_rv)) begin
        n_bad++;
        $display("FAIL badlen_status len=%0d got %0d want 2", lens[i], st);
      end
      if (ref_valid !== model_rv) begin
        n_bad++;
        $display("FAIL badlen_ref_valid got %b want %b", ref_valid, model_rv);
      end
    end
  endtask

  task automatic test_load();
    bit ok, got;
    logic [1:0] st;
    logic b;
    int w, p0;
    empty_mode = 0;
    p0 = pop_total;
    send_cmd(1'b1, 32'd8, ok);
    wait_rsp(500, got, st, w, b);
    model_rv = 1'b1;
    n_cmp += 4;
    if (!(ok && got) || st !== 2'd0) begin n_bad++; $display("FAIL load8_status got %0d want 0", st); end
    if (pop_total - p0 != 8) begin n_bad++; $display("FAIL load8_pops got %0d want 8", pop_total - p0); end
    if (ref_valid !== 1'b1) begin n_bad++; $display("FAIL load8_ref_valid got %b want 1", ref_valid); end
    if (core_ref_len !== 32'd8) begin n_bad++; $display("FAIL load8_ref_len got %0d want 8", core_ref_len); end
  endtask

  task automatic test_query();
    bit ok, got;
    logic [1:0] st;
    logic b;
    int w, p0;
    empty_mode = 1;
    p0 = pop_total;
    send_cmd(1'b0, 32'd0, ok);
    wait_rsp(3000, got, st, w, b);
    empty_mode = 0;
    n_cmp += 4;
    if (!(ok && got) || st !== ref_status(1'b0, 0, model_rv)) begin n_bad++; $display("FAIL query_status got %0d want 0", st); end
    if (pop_total - p0 != SQG) begin n_bad++; $display("FAIL query_pops got %0d want %0d", pop_total - p0, SQG); end
    if (b !== 1'b0) begin n_bad++; $display("FAIL query_busy_at_rsp got %b want 0", b); end
    if (ref_valid !== 1'b1) begin n_bad++; $display("FAIL query_ref_valid got %b want 1", ref_valid); end
  endtask

  task automatic test_back_to_back();
    bit ok, got;
    logic [1:0] st;
    logic b;
    int w;
    send_cmd(1'b0, 32'd0, ok);
    w = 0;
    while (!rsp_valid && w < 3000) begin
      @(negedge clk);
      w++;
    end
    n_cmp += 1;
    if (!(ok && rsp_valid)) begin n_bad++; $display("FAIL b2b_first_rsp got %b want 1", rsp_valid); end
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 1'b1;
    cmd_len = 32'd0;
    n_cmp += 1;
    if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_in_resp got %b want 0", cmd_ready); end
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp += 2;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_next got %b want 1", cmd_ready); end
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_rsp_dropped got %b want 0", rsp_valid); end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_rsp(10, got, st, w, b);
    n_cmp += 1;
    if (!got || st !== 2'd2 || w != 0) begin
      n_bad++;
      $display("FAIL b2b_second got rsp=%b st=%0d wait=%0d want 1/2/0", got, st, w);
    end
  endtask

  task automatic test_random_cmds();
    bit ok, got, op;
    logic [1:0] st, est;
    logic b;
    logic [31:0] len;
    int w, p0, sel;
    empty_mode = 2;
    for (int i = 0; i < 8; i++) begin
      op = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 5);
      if (sel == 0) len = 32'd0;
      else if (sel == 1) len = 32'(RMAX + 1 + $urandom_range(0, 1000));
      else len = 32'($urandom_range(1, 40));
      est = ref_status(op, len, model_rv);
      p0 = pop_total;
      send_cmd(op, len, ok);
      wait_rsp(3000, got, st, w, b);
      if (op && est == 2'd0) model_rv = 1'b1;
      n_cmp += 3;
      if (!(ok && got) || st !== est) begin
        n_bad++;
        $display("FAIL rnd%0d_status op=%0d len=%0d got %0d want %0d", i, op, len, st, est);
      end
      if (pop_total - p0 != ref_pops(op, len, est)) begin
        n_bad++;
        $display("FAIL rnd%0d_pops got %0d want %0d", i, pop_total - p0, ref_pops(op, len, est));
      end
      if (ref_valid !== model_rv) begin
        n_bad++;
        $display("FAIL rnd%0d_ref_valid got %b want %b", i, ref_valid, model_rv);
      end
    end
    empty_mode = 0;
  endtask

  task automatic test_timeout();
    bit ok, got;
    logic [1:0] st;
    logic b;
    int w, c0;
    never_done = 1'b1;
    c0 = crst_hi;
    send_cmd(1'b1, 32'd8, ok);
    wait_rsp(1000, got, st, w, b);
    never_done = 1'b0;
    model_rv = 1'b0;
    n_cmp += 4;
    if (!(ok && got) || st !== 2'd3) begin n_bad++; $display("FAIL tmo_status got %0d want 3", st); end
    if (crst_hi - c0 != 2 * RSTC) begin n_bad++; $display("FAIL tmo_core_rst got %0d cycles want %0d", crst_hi - c0, 2 * RSTC); end
    if (ref_valid !== model_rv) begin n_bad++; $display("FAIL tmo_ref_valid got %b want 0", ref_valid); end
    if (w < TMO) begin n_bad++; $display("FAIL tmo_latency got %0d want >=%0d", w, TMO); end
  endtask

  task automatic test_rst_mid();
    bit ok, got;
    logic [1:0] st;
    logic b;
    int w, p0;
    send_cmd(1'b1, 32'd5, ok);
    wait_rsp(500, got, st, w, b);
    model_rv = (ok && got && st == 2'd0);
    p0 = pop_total;
    send_cmd(1'b0, 32'd0, ok);
    w = 0;
    while (pop_total - p0 < 100 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    n_cmp += 1;
    if (pop_total - p0 != 100) begin n_bad++; $display("FAIL rstmid_pops got %0d want 100", pop_total - p0); end
    rst = 1'b1;
    #1;
    n_cmp += 3;
    if (ref_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_ref_valid got %b want 0", ref_valid); end
    if (core_rst !== 1'b1) begin n_bad++; $display("FAIL rstmid_core_rst got %b want 1", core_rst); end
    if (core_src_empty !== 1'b1) begin n_bad++; $display("FAIL rstmid_src_empty got %b want 1", core_src_empty); end
    @(negedge clk);
    rst = 1'b0;
    model_rv = 1'b0;
    send_cmd(1'b0, 32'd0, ok);
    w = 0;
    while (!rsp_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp += 1;
      if (rsp_valid !== 1'b1 || rsp_status !== ref_status(1'b0, 0, model_rv)) begin
        n_bad++;
        $display("FAIL rstmid_hold%0d got v=%b st=%0d want 1/1", i, rsp_valid, rsp_status);
      end
      @(negedge clk);
    end
    wait_rsp(10, got, st, w, b);
    @(negedge clk);
    n_cmp += 2;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_idle got %b want 1", cmd_ready); end
    if (overpop != 0) begin n_bad++; $display("FAIL overpop got %0d want 0", overpop); end
  endtask

  initial begin
    test_reset();
    test_noref();
    test_badlen();
    test_load();
    test_badlen();
    test_query();
    test_back_to_back();
    test_random_cmds();
    test_timeout();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
